uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- UART receive framer; sits directly downstream of the 2-flop input synchronizer in the UART RX path.
- Consumes the synchronized serial line and recovers 8N1-style frames: start bit, DATA_BITS data bits LSB first, one stop bit.
- Presents each received word on a valid/ready holding register.
- Flags framing errors and overruns to the UART top.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period; must be ≥ 4 and even (50 MHz / 115200).
- DATA_BITS, 8, data bits per frame; range 5..9.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx_sync  input  1  serial line, already synchronized to clk; idle high
- rx_data  output  DATA_BITS  received word; stable while rx_valid is high
- rx_valid  output  1  word available; level signal, held until accepted
- rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun_err  output  1  one-cycle pulse: new word arrived while the previous one was unaccepted
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a clk edge):
  - state IDLE; bit counter and cycle counter cleared.
  - rx_data = 0, rx_valid = 0, frame_err = 0, overrun_err = 0, busy = 0.
  - Reset mid-frame aborts the frame; no partial word is ever output.
- HALF = CLKS_PER_BIT/2. cnt is a cycle counter of width $clog2(CLKS_PER_BIT).
- IDLE:
  - rx_sync == 0 sampled at edge t0 → START, cnt = 0.
- START:
  - cnt increments each cycle.
  - At cnt == HALF-1 (sample point t0+HALF), rx_sync is sampled.
  - Sample == 1 → false start: return to IDLE, no error.
  - Sample == 0 → DATA with cnt = 0, bitidx = 0.
- DATA:
  - At cnt == CLKS_PER_BIT-1, sample rx_sync into shift[bitidx] (LSB first), then cnt = 0 and bitidx++.
  - Data bit i is sampled at t0 + HALF + (i+1)·CLKS_PER_BIT.
  - After bit DATA_BITS-1 → STOP.
- STOP:
  - At cnt == CLKS_PER_BIT-1, sample rx_sync.
  - Sample == 1 → deliver the word (see below), then IDLE. A new start edge is accepted on the very next cycle.
  - Sample == 0 → frame_err pulses on the next cycle, the word is discarded, state → BREAK.
- BREAK:
  - Stay until rx_sync == 1, then IDLE. A line held low is never re-framed.
- Deliver:
  - On the cycle after the stop sample, rx_data ← shift and rx_valid ← 1.
  - Total latency is t0 + HALF + (DATA_BITS+1)·CLKS_PER_BIT + 1.
- Handshake:
  - rx_valid && rx_ready at an edge → rx_valid ← 0, unless a word is delivered on that same edge.
  - If a word is delivered on that same edge, the old word is consumed, the new word is loaded, rx_valid stays 1, and there is no overrun.
  - Delivery while rx_valid == 1 and rx_ready == 0:
    - rx_data is overwritten with the new word; rx_valid stays 1.
    - overrun_err pulses for one cycle.
- rx_ready is ignored while rx_valid == 0.
- frame_err and overrun_err are registered, never asserted together, and low in all other cycles.
- rx_sync glitches are not filtered; a single mid-bit sample is authoritative.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP, BREAK) with 3-bit encoding;
  - default constants CLK_FREQ_HZ = 50_000_000, BAUD = 115200, CLKS_PER_BIT_DEF = CLK_FREQ_HZ/BAUD, DATA_BITS_DEF = 8.
- No sub-module: the counters and FSM stay in one module. Input synchronization is done by the existing synchronizer instantiated upstream at the UART top.

Test Plan:
- CLKS_PER_BIT=16; send 0x55 with rx_ready tied 1, start edge sampled at t0 → rx_valid high exactly at t0+153 with rx_data=0x55, low the next cycle, no error pulses.
- Send 0xA3 with rx_ready=0, then a second frame 0x3C → first word held with rx_valid=1; at the second delivery overrun_err pulses once and rx_data=0x3C.
- Send 0x81 with a low stop bit held low for 40 more cycles → frame_err pulses once, rx_valid stays 0, busy stays high until rx_sync returns high; a following frame 0x7E is received correctly.
- rx_sync low for 5 cycles only (glitch shorter than HALF) → back to IDLE after the start sample; no rx_valid, no error pulses.
- Assert rst for 1 cycle during data bit 4 of a frame → all outputs 0 the next cycle, state IDLE; the next full frame 0xF0 is received correctly.
- Back-to-back frames 0x00, 0xFF with no idle gap, and rx_ready asserted on the delivery cycle of the second frame → both words delivered, no overrun, rx_valid continuous across the handover.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default line-rate constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    localparam int CLK_FREQ_HZ      = 50_000_000;
    localparam int BAUD             = 115200;
    localparam int CLKS_PER_BIT_DEF = CLK_FREQ_HZ / BAUD;
    localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Received-word handshake and status bundle between the RX framer (master) and its consumer (slave).
interface uart_rx_frame_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun_err, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun_err, busy,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_frame.sv
// UART receive framer: recovers start/data/stop frames from the synchronized line and
// presents each word on a valid/ready holding register with framing and overrun flags.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_sync,
    uart_rx_frame_if.master  rx_if
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT     = BW'(DATA_BITS - 1);

    uart_state_e          r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bitidx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun_err;
    logic                 r_deliver;
    logic                 r_ferr_pend;
    logic                 w_bit_end;

    assign w_bit_end = (r_cnt == CNT_BIT_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bitidx      <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_deliver     <= 1'b0;
            r_ferr_pend   <= 1'b0;
        end else begin
            r_deliver     <= 1'b0;
            r_ferr_pend   <= 1'b0;
            r_frame_err   <= r_ferr_pend;
            r_overrun_err <= 1'b0;
            r_cnt         <= r_cnt + 1'b1;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!rx_sync) begin
                        r_state <= START;
                    end
                end
                START: begin
                    // Mid-start sample: a line already back high was only a glitch.
                    if (r_cnt == CNT_HALF_END) begin
                        r_cnt    <= '0;
                        r_bitidx <= '0;
                        r_state  <= rx_sync ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift[r_bitidx] <= rx_sync;
                        r_cnt             <= '0;
                        r_bitidx          <= r_bitidx + 1'b1;
                        if (r_bitidx == LAST_BIT) begin
                            r_state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (rx_sync) begin
                            r_deliver <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_ferr_pend <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // A held-low line must return high before another start is framed.
                    r_cnt <= '0;
                    if (rx_sync) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase

            // A delivery on an accepting edge is a handover, not an overrun.
            if (r_deliver) begin
                r_data        <= r_shift;
                r_valid       <= 1'b1;
                r_overrun_err <= r_valid && !rx_if.rx_ready;
            end else if (r_valid && rx_if.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data     = r_data;
    assign rx_if.rx_valid    = r_valid;
    assign rx_if.frame_err   = r_frame_err;
    assign rx_if.overrun_err = r_overrun_err;
    assign rx_if.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: drives serial frames and checks per-cycle output logs
// against delivery times and word-holding behaviour derived from the frame timing rules.
module tb_uart_rx_frame;

    localparam int CPB  = 16;
    localparam int DB   = 8;
    localparam int HALF = CPB / 2;
    localparam int LOGN = 16384;

    logic clk = 1'b0;
    logic rst;
    logic rx_sync;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    uart_rx_frame_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_frame #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_sync(rx_sync),
        .rx_if  (rx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output log indexed by the number of the clock edge that produced the value.
    logic          valid_log [LOGN];
    logic [DB-1:0] data_log  [LOGN];
    logic          ferr_log  [LOGN];
    logic          ovr_log   [LOGN];
    logic          busy_log  [LOGN];

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            valid_log[cyc] <= rx_if.rx_valid;
            data_log[cyc]  <= rx_if.rx_data;
            ferr_log[cyc]  <= rx_if.frame_err;
            ovr_log[cyc]   <= rx_if.overrun_err;
            busy_log[cyc]  <= rx_if.busy;
        end
    end

    // Start seen at edge t0: mid-start at t0+HALF, stop mid-bit DATA_BITS+1 periods later, word one edge after.
    function automatic int deliver_cycle(input int t0);
        return t0 + HALF + (DB + 1) * CPB + 1;
    endfunction

    // sel: 0 valid, 1 frame_err, 2 overrun_err
    function automatic int count_log(input int sel, input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            case (sel)
                0:       if (valid_log[i] === 1'b1) n++;
                1:       if (ferr_log[i]  === 1'b1) n++;
                default: if (ovr_log[i]   === 1'b1) n++;
            endcase
        end
        return n;
    endfunction

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic drive_bits(input logic level, input int n);
        repeat (n) begin
            rx_sync = level;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] w, input logic stop, input int extra, output int t0);
        t0 = cyc + 1;
        $display("frame data=%h stop=%0d t0=%0d ready=%0d", w, stop, t0, rx_if.rx_ready);
        drive_bits(1'b0, CPB);
        for (int i = 0; i < DB; i++) drive_bits(w[i], CPB);
        drive_bits(stop, CPB + extra);
        rx_sync = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_sync = 1'b1;
        rx_if.rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rx_if.rx_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rx_if.rx_valid); else n_pass++;
        n_checks++; if (rx_if.rx_data !== '0) $display("FAIL reset_data: got %h expected 00", rx_if.rx_data); else n_pass++;
        n_checks++; if (rx_if.frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", rx_if.frame_err); else n_pass++;
        n_checks++; if (rx_if.overrun_err !== 1'b0) $display("FAIL reset_ovr: got %b expected 0", rx_if.overrun_err); else n_pass++;
        n_checks++; if (rx_if.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", rx_if.busy); else n_pass++;
        rst = 1'b0;
        drive_bits(1'b1, 2);
    endtask

    task automatic test_single;
        int t0, d;
        rx_if.rx_ready = 1'b1;
        send_frame(8'h55, 1'b1, 0, t0);
        drive_bits(1'b1, 20);
        d = deliver_cycle(t0);
        n_checks++; if (valid_log[d-1] !== 1'b0) $display("FAIL single_early: got valid=%b at %0d expected 0", valid_log[d-1], d-1); else n_pass++;
        n_checks++; if (valid_log[d] !== 1'b1) $display("FAIL single_valid: got %b at %0d expected 1", valid_log[d], d); else n_pass++;
        n_checks++; if (data_log[d] !== 8'h55) $display("FAIL single_data: got %h expected 55", data_log[d]); else n_pass++;
        n_checks++; if (valid_log[d+1] !== 1'b0) $display("FAIL single_accept: got valid=%b expected 0", valid_log[d+1]); else n_pass++;
        n_checks++; if (busy_log[t0] !== 1'b1) $display("FAIL single_busy_start: got %b expected 1", busy_log[t0]); else n_pass++;
        n_checks++; if (busy_log[d-1] !== 1'b0) $display("FAIL single_busy_idle: got %b expected 0", busy_log[d-1]); else n_pass++;
        n_checks++; if (count_log(1, t0, d+15) + count_log(2, t0, d+15) !== 0) $display("FAIL single_errs: got %0d pulses expected 0", count_log(1, t0, d+15) + count_log(2, t0, d+15)); else n_pass++;
    endtask

    task automatic test_overrun;
        int ta, tb, da, db;
        rx_if.rx_ready = 1'b0;
        send_frame(8'hA3, 1'b1, 0, ta);
        drive_bits(1'b1, 10);
        send_frame(8'h3C, 1'b1, 0, tb);
        drive_bits(1'b1, 10);
        da = deliver_cycle(ta);
        db = deliver_cycle(tb);
        n_checks++; if (data_log[da] !== 8'hA3 || valid_log[da] !== 1'b1) $display("FAIL ovr_first: got valid=%b data=%h expected 1/a3", valid_log[da], data_log[da]); else n_pass++;
        n_checks++; if (valid_log[db-1] !== 1'b1 || data_log[db-1] !== 8'hA3) $display("FAIL ovr_held: got valid=%b data=%h expected 1/a3", valid_log[db-1], data_log[db-1]); else n_pass++;
        n_checks++; if (ovr_log[db] !== 1'b1) $display("FAIL ovr_pulse: got %b expected 1", ovr_log[db]); else n_pass++;
        n_checks++; if (count_log(2, da-2, db+5) !== 1) $display("FAIL ovr_count: got %0d expected 1", count_log(2, da-2, db+5)); else n_pass++;
        n_checks++; if (data_log[db] !== 8'h3C || valid_log[db] !== 1'b1) $display("FAIL ovr_new: got valid=%b data=%h expected 1/3c", valid_log[db], data_log[db]); else n_pass++;
        rx_if.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (rx_if.rx_valid !== 1'b0) $display("FAIL ovr_drain: got %b expected 0", rx_if.rx_valid); else n_pass++;
    endtask

    task automatic test_frame_err;
        int t0, t1, d;
        rx_if.rx_ready = 1'b1;
        send_frame(8'h81, 1'b0, 40, t0);
        drive_bits(1'b1, 20);
        d = deliver_cycle(t0);
        n_checks++; if (ferr_log[d] !== 1'b1) $display("FAIL ferr_pulse: got %b at %0d expected 1", ferr_log[d], d); else n_pass++;
        n_checks++; if (count_log(1, t0, t0+215) !== 1) $display("FAIL ferr_count: got %0d expected 1", count_log(1, t0, t0+215)); else n_pass++;
        n_checks++; if (count_log(0, t0, t0+215) !== 0) $display("FAIL ferr_novalid: got %0d valid cycles expected 0", count_log(0, t0, t0+215)); else n_pass++;
        n_checks++; if (busy_log[t0+199] !== 1'b1) $display("FAIL ferr_busy_low: got %b expected 1", busy_log[t0+199]); else n_pass++;
        n_checks++; if (busy_log[t0+200] !== 1'b0) $display("FAIL ferr_busy_release: got %b expected 0", busy_log[t0+200]); else n_pass++;
        send_frame(8'h7E, 1'b1, 0, t1);
        drive_bits(1'b1, 20);
        d = deliver_cycle(t1);
        n_checks++; if (valid_log[d] !== 1'b1 || data_log[d] !== 8'h7E) $display("FAIL ferr_recover: got valid=%b data=%h expected 1/7e", valid_log[d], data_log[d]); else n_pass++;
    endtask

    task automatic test_glitch;
        int t0;
        t0 = cyc + 1;
        $display("glitch low for 5 cycles t0=%0d", t0);
        drive_bits(1'b0, 5);
        drive_bits(1'b1, 30);
        n_checks++; if (busy_log[t0+HALF-1] !== 1'b1) $display("FAIL glitch_busy: got %b expected 1", busy_log[t0+HALF-1]); else n_pass++;
        n_checks++; if (busy_log[t0+HALF] !== 1'b0) $display("FAIL glitch_idle: got %b expected 0", busy_log[t0+HALF]); else n_pass++;
        n_checks++; if (count_log(0, t0, t0+33) + count_log(1, t0, t0+33) + count_log(2, t0, t0+33) !== 0) $display("FAIL glitch_quiet: got %0d active cycles expected 0", count_log(0, t0, t0+33) + count_log(1, t0, t0+33) + count_log(2, t0, t0+33)); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int t0, t1, d;
        logic [DB-1:0] w;
        w = 8'hF0 | DB'($urandom_range(0, 15));
        rx_if.rx_ready = 1'b1;
        fork
            begin
                send_frame(w, 1'b1, 0, t0);
                drive_bits(1'b1, 30);
            end
            begin
                repeat (84) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                n_checks++; if ({rx_if.rx_valid, rx_if.frame_err, rx_if.overrun_err, rx_if.busy} !== 4'b0000) $display("FAIL midrst_flags: got %b expected 0000", {rx_if.rx_valid, rx_if.frame_err, rx_if.overrun_err, rx_if.busy}); else n_pass++;
                n_checks++; if (rx_if.rx_data !== '0) $display("FAIL midrst_data: got %h expected 00", rx_if.rx_data); else n_pass++;
            end
        join
        n_checks++; if (count_log(0, t0+84, t0+185) !== 0) $display("FAIL midrst_partial: got %0d valid cycles expected 0", count_log(0, t0+84, t0+185)); else n_pass++;
        send_frame(8'hF0, 1'b1, 0, t1);
        drive_bits(1'b1, 20);
        d = deliver_cycle(t1);
        n_checks++; if (valid_log[d] !== 1'b1 || data_log[d] !== 8'hF0) $display("FAIL midrst_next: got valid=%b data=%h expected 1/f0", valid_log[d], data_log[d]); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int ta, tb, d1, d2;
        rx_if.rx_ready = 1'b0;
        fork
            begin
                send_frame(8'h00, 1'b1, 0, ta);
                send_frame(8'hFF, 1'b1, 0, tb);
                drive_bits(1'b1, 20);
            end
            begin
                // Raise ready just before the second word lands.
                repeat (313) @(posedge clk);
                #1 rx_if.rx_ready = 1'b1;
            end
        join
        d1 = deliver_cycle(ta);
        d2 = deliver_cycle(tb);
        n_checks++; if (valid_log[d1-1] !== 1'b0) $display("FAIL b2b_pre: got %b expected 0", valid_log[d1-1]); else n_pass++;
        n_checks++; if (count_log(0, d1, d2) !== d2 - d1 + 1) $display("FAIL b2b_continuous: got %0d valid cycles expected %0d", count_log(0, d1, d2), d2 - d1 + 1); else n_pass++;
        n_checks++; if (data_log[d2-1] !== 8'h00) $display("FAIL b2b_first: got %h expected 00", data_log[d2-1]); else n_pass++;
        n_checks++; if (data_log[d2] !== 8'hFF) $display("FAIL b2b_second: got %h expected ff", data_log[d2]); else n_pass++;
        n_checks++; if (count_log(2, d1-1, d2+3) !== 0) $display("FAIL b2b_no_ovr: got %0d expected 0", count_log(2, d1-1, d2+3)); else n_pass++;
        n_checks++; if (valid_log[d2+1] !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", valid_log[d2+1]); else n_pass++;
    endtask

    // Random words, gaps and ready levels against a one-entry holding-register model.
    task automatic test_random;
        int t0, d, gap;
        logic [DB-1:0] w;
        logic r, model_valid, exp_ovr;
        model_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            w   = DB'($urandom);
            gap = $urandom_range(1, 40);
            r   = 1'($urandom_range(0, 1));
            rx_if.rx_ready = r;
            if (r) model_valid = 1'b0;
            exp_ovr = model_valid;
            send_frame(w, 1'b1, 0, t0);
            drive_bits(1'b1, gap);
            d = deliver_cycle(t0);
            n_checks++; if (valid_log[d] !== 1'b1) $display("FAIL rand_valid[%0d]: got %b expected 1", k, valid_log[d]); else n_pass++;
            n_checks++; if (data_log[d] !== w) $display("FAIL rand_data[%0d]: got %h expected %h", k, data_log[d], w); else n_pass++;
            n_checks++; if (ovr_log[d] !== exp_ovr) $display("FAIL rand_ovr[%0d]: got %b expected %b", k, ovr_log[d], exp_ovr); else n_pass++;
            model_valid = !r;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
